ftb_v2: RTL

FTB_V2 -- requirements
Module: ftb_v2

---
 rtl/ftb_v2_if.sv | 34 +++
 rtl/ftb_v2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ftb_v2_if.sv
// Lookup/update port bundle of the fetch target buffer.
// slave is the FTB side; master is the front-end that drives it.
interface ftb_v2_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned INFO_W = 64
);
  logic              i_squash_vld;
  logic              i_lookup_req;
  logic              o_lookup_gnt;
  logic [XLEN-1:0]   i_lookup_pc;
  logic              o_lookup_vld;
  logic              o_lookup_hit;
  logic [INFO_W-1:0] o_lookup_info;
  logic              i_update_req;
  logic              o_update_gnt;
  logic [XLEN-1:0]   i_update_pc;
  logic              i_update_inv;
  logic [INFO_W-1:0] i_update_info;
  logic              o_update_idle;

  modport slave (
    input  i_squash_vld, i_lookup_req, i_lookup_pc,
    input  i_update_req, i_update_pc, i_update_inv, i_update_info,
    output o_lookup_gnt, o_lookup_vld, o_lookup_hit, o_lookup_info,
    output o_update_gnt, o_update_idle
  );

  modport master (
    output i_squash_vld, i_lookup_req, i_lookup_pc,
    output i_update_req, i_update_pc, i_update_inv, i_update_info,
    input  o_lookup_gnt, o_lookup_vld, o_lookup_hit, o_lookup_info,
    input  o_update_gnt, o_update_idle
  );
endinterface

// File: rtl/ftb_v2.sv
// Set-associative fetch target buffer: single-ported array shared by lookups
// and a queued two-stage (read U0, compare/write U1) update pipeline.
module ftb_v2 #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned SETS       = 64,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned TAG_W      = 20,
  parameter int unsigned INFO_W     = 64,
  parameter int unsigned IDX_LSB    = 1,
  parameter int unsigned UPD_QDEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  ftb_v2_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned QAW   = $clog2(UPD_QDEPTH);

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_U1WR,
    ACC_U0RD,
    ACC_LKRD
  } acc_e;

  // Array state
  logic [SETS-1:0][WAYS-1:0]  r_valid;
  logic [SETS-1:0][WAY_W-1:0] r_vptr;
  logic [WAYS-1:0][TAG_W-1:0]  r_tag  [SETS];
  logic [WAYS-1:0][INFO_W-1:0] r_info [SETS];

  // Update queue
  logic [XLEN-1:0]   r_q_pc   [UPD_QDEPTH];
  logic              r_q_inv  [UPD_QDEPTH];
  logic [INFO_W-1:0] r_q_info [UPD_QDEPTH];
  logic [QAW:0]      r_q_wp;
  logic [QAW:0]      r_q_rp;
  logic              w_q_full;
  logic              w_q_empty;
  logic              w_push;
  logic [XLEN-1:0]   w_head_pc;
  logic [IDX_W-1:0]  w_head_idx;

  // U1 stage
  logic                        r_u1_vld;
  logic [IDX_W-1:0]            r_u1_idx;
  logic [TAG_W-1:0]            r_u1_tag;
  logic                        r_u1_inv;
  logic [INFO_W-1:0]           r_u1_info;
  logic [WAYS-1:0]             r_u1_valid;
  logic [WAYS-1:0][TAG_W-1:0]  r_u1_tags;
  logic [WAY_W-1:0]            r_u1_vptr;
  logic                        w_u1_hit;
  logic [WAY_W-1:0]            w_u1_hway;
  logic                        w_u1_free;
  logic [WAY_W-1:0]            w_u1_fway;
  logic [WAY_W-1:0]            w_u1_way;
  logic                        w_u1_wr;
  logic                        w_u1_adv;

  // Lookup response stage
  logic                        r_lk_pend;
  logic [TAG_W-1:0]            r_lk_tagq;
  logic [WAYS-1:0]             r_lk_valid;
  logic [WAYS-1:0][TAG_W-1:0]  r_lk_tags;
  logic [WAYS-1:0][INFO_W-1:0] r_lk_info;
  logic                        w_lk_hit;
  logic [INFO_W-1:0]           w_lk_info;
  logic [IDX_W-1:0]            w_lk_idx;

  acc_e w_acc;

  assign w_q_empty  = (r_q_wp == r_q_rp);
  assign w_q_full   = (r_q_wp[QAW] != r_q_rp[QAW]) &&
                      (r_q_wp[QAW-1:0] == r_q_rp[QAW-1:0]);
  assign w_push     = bus.i_update_req && !w_q_full;
  assign w_head_pc  = r_q_pc[r_q_rp[QAW-1:0]];
  assign w_head_idx = w_head_pc[IDX_LSB +: IDX_W];
  assign w_lk_idx   = bus.i_lookup_pc[IDX_LSB +: IDX_W];

  // Tag match and allocation choice for the update in U1
  always_comb begin
    w_u1_hit  = 1'b0;
    w_u1_hway = '0;
    w_u1_free = 1'b0;
    w_u1_fway = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_u1_valid[w] && (r_u1_tags[w] == r_u1_tag)) begin
        w_u1_hit  = 1'b1;
        w_u1_hway = WAY_W'(w);
      end
      if (!r_u1_valid[w] && !w_u1_free) begin
        w_u1_free = 1'b1;
        w_u1_fway = WAY_W'(w);
      end
    end
  end

  // An invalidate that misses claims no array slot
  assign w_u1_wr  = r_u1_vld && !(r_u1_inv && !w_u1_hit);
  assign w_u1_way = w_u1_hit ? w_u1_hway : (w_u1_free ? w_u1_fway : r_u1_vptr);
  assign w_u1_adv = !r_u1_inv && !w_u1_hit && !w_u1_free;

  always_comb begin
    w_acc = ACC_NONE;
    if (w_u1_wr) begin
      w_acc = ACC_U1WR;
    end else if (w_q_full) begin
      w_acc = ACC_U0RD;
    end else if (bus.i_lookup_req) begin
      w_acc = ACC_LKRD;
    end else if (!w_q_empty) begin
      w_acc = ACC_U0RD;
    end
  end

  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_info = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_lk_valid[w] && (r_lk_tags[w] == r_lk_tagq)) begin
        w_lk_hit  = 1'b1;
        w_lk_info = r_lk_info[w];
      end
    end
  end

  assign bus.o_lookup_gnt  = (w_acc == ACC_LKRD);
  assign bus.o_lookup_vld  = r_lk_pend && !bus.i_squash_vld;
  assign bus.o_lookup_hit  = bus.o_lookup_vld && w_lk_hit;
  assign bus.o_lookup_info = bus.o_lookup_vld ? w_lk_info : '0;
  assign bus.o_update_gnt  = !w_q_full;
  assign bus.o_update_idle = w_q_empty && !r_u1_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= '0;
      r_vptr    <= '0;
      r_q_wp    <= '0;
      r_q_rp    <= '0;
      r_u1_vld  <= 1'b0;
      r_lk_pend <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_wp <= r_q_wp + 1'b1;
      end
      if (w_acc == ACC_U0RD) begin
        r_q_rp <= r_q_rp + 1'b1;
      end
      r_u1_vld  <= (w_acc == ACC_U0RD);
      r_lk_pend <= (w_acc == ACC_LKRD) && !bus.i_squash_vld;
      if (w_u1_wr) begin
        r_valid[r_u1_idx][w_u1_way] <= !r_u1_inv;
        if (w_u1_adv) begin
          r_vptr[r_u1_idx] <= r_u1_vptr + 1'b1;
        end
      end
    end
  end

  // Payload storage and stage capture; control bits above gate their use
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_q_wp[QAW-1:0]]   <= bus.i_update_pc;
      r_q_inv[r_q_wp[QAW-1:0]]  <= bus.i_update_inv;
      r_q_info[r_q_wp[QAW-1:0]] <= bus.i_update_info;
    end
    if (w_acc == ACC_U0RD) begin
      r_u1_idx   <= w_head_idx;
      r_u1_tag   <= w_head_pc[IDX_LSB+IDX_W +: TAG_W];
      r_u1_inv   <= r_q_inv[r_q_rp[QAW-1:0]];
      r_u1_info  <= r_q_info[r_q_rp[QAW-1:0]];
      r_u1_valid <= r_valid[w_head_idx];
      r_u1_tags  <= r_tag[w_head_idx];
      r_u1_vptr  <= r_vptr[w_head_idx];
    end
    if (w_acc == ACC_LKRD) begin
      r_lk_tagq  <= bus.i_lookup_pc[IDX_LSB+IDX_W +: TAG_W];
      r_lk_valid <= r_valid[w_lk_idx];
      r_lk_tags  <= r_tag[w_lk_idx];
      r_lk_info  <= r_info[w_lk_idx];
    end
    if (w_u1_wr && !r_u1_inv) begin
      r_tag[r_u1_idx][w_u1_way]  <= r_u1_tag;
      r_info[r_u1_idx][w_u1_way] <= r_u1_info;
    end
  end

endmodule
